// File: rtl/decimal_binary_pkg.sv
// Shared constants, state encoding and result payload for the keypad decimal-to-binary converter.
package decimal_binary_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned ACC_W   = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MAX_INT = 99;

    localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [KEY_W-1:0] KEY_COMMIT    = 4'd10;
    localparam logic [KEY_W-1:0] KEY_POINT     = 4'd11;

    // Half-unit digits, shared with the display-side digit path
    localparam logic [KEY_W-1:0] HALF_ZERO = 4'd0;
    localparam logic [KEY_W-1:0] HALF_FIVE = 4'd5;

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_INT1  = 3'd1,
        S_INT2  = 3'd2,
        S_POINT = 3'd3,
        S_FRAC  = 3'd4
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              decimal;
    } result_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/decimal_binary_mul10_add.sv
// Combinational acc*10+digit using a shift-add, evaluated at 8 bits.
module mul10_add
    import decimal_binary_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    input  logic [KEY_W-1:0]  digit,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W-1:0] acc_ext;

    assign acc_ext  = DATA_W'(acc);
    assign result_c = (acc_ext << 3) + (acc_ext << 1) + DATA_W'(digit);

endmodule

// File: rtl/decimal_binary.sv
// Keypad-side decimal-to-binary converter: serial key codes in, binary whole value and half flag out.
// Optional idle timeout enabled by defining DECIMAL_BINARY_TIMEOUT_EN.
module decimal_binary
    import decimal_binary_pkg::*;
`ifdef DECIMAL_BINARY_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              digit_valid,
    input  logic [KEY_W-1:0]  digit,
    output logic [DATA_W-1:0] data,
    output logic              decimal,
    output logic              data_valid,
    output logic              error,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               frac_q, frac_d;
    result_t            res_q, res_d;
    logic               data_valid_q, data_valid_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  prod_c;
    logic               publish;
    logic               abandon;
    logic               timeout;

    mul10_add u_mul10_add (
        .acc      (acc_q),
        .digit    (digit),
        .result_c (prod_c)
    );

`ifdef DECIMAL_BINARY_TIMEOUT_EN
    localparam int unsigned IDLE_W = 26;

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Idle counter runs only while a partial entry is held and no key arrives
    always_comb begin
        timeout = 1'b0;
        idle_d  = '0;
        if (!digit_valid && busy_q) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        frac_d       = frac_q;
        res_d        = res_q;
        data_valid_d = 1'b0;
        error_d      = 1'b0;
        publish      = 1'b0;
        abandon      = 1'b0;

        if (digit_valid) begin
            case (state_q)
                S_EMPTY: begin
                    if (is_digit(digit)) begin
                        acc_d   = ACC_W'(digit);
                        state_d = S_INT1;
                    end else if (digit == KEY_POINT) begin
                        acc_d   = '0;
                        state_d = S_POINT;
                    end else begin
                        abandon = 1'b1;
                    end
                end
                S_INT1: begin
                    if (is_digit(digit)) begin
                        acc_d   = ACC_W'(prod_c);
                        state_d = S_INT2;
                    end else if (digit == KEY_POINT) begin
                        state_d = S_POINT;
                    end else if (digit == KEY_COMMIT) begin
                        publish = 1'b1;
                    end else begin
                        abandon = 1'b1;
                    end
                end
                S_INT2: begin
                    if (digit == KEY_POINT) begin
                        state_d = S_POINT;
                    end else if (digit == KEY_COMMIT) begin
                        publish = 1'b1;
                    end else begin
                        abandon = 1'b1;
                    end
                end
                S_POINT: begin
                    if (digit == HALF_ZERO) begin
                        frac_d  = 1'b0;
                        state_d = S_FRAC;
                    end else if (digit == HALF_FIVE) begin
                        frac_d  = 1'b1;
                        state_d = S_FRAC;
                    end else begin
                        abandon = 1'b1;
                    end
                end
                S_FRAC: begin
                    if (digit == KEY_COMMIT) begin
                        publish = 1'b1;
                    end else begin
                        abandon = 1'b1;
                    end
                end
                default: abandon = 1'b1;
            endcase
        end else if (timeout) begin
            abandon = 1'b1;
        end

        // Out-of-range commits are rejected without touching the published value
        if (publish) begin
            if (acc_q > ACC_W'(MAX_INT)) begin
                error_d = 1'b1;
            end else begin
                res_d.data    = DATA_W'(acc_q);
                res_d.decimal = frac_q;
                data_valid_d  = 1'b1;
            end
        end
        if (abandon) begin
            error_d = 1'b1;
        end
        if (publish || abandon) begin
            acc_d   = '0;
            frac_d  = 1'b0;
            state_d = S_EMPTY;
        end

        busy_d = (state_d != S_EMPTY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_EMPTY;
            acc_q        <= '0;
            frac_q       <= 1'b0;
            res_q        <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            frac_q       <= frac_d;
            res_q        <= res_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = res_q.data;
    assign decimal    = res_q.decimal;
    assign data_valid = data_valid_q;
    assign error      = error_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_decimal_binary.sv
// Directed bench for decimal_binary: entry-level model checked every cycle plus literal spot checks.
module tb_decimal_binary;

    logic       clk = 1'b0;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic [7:0] data;
    logic       decimal;
    logic       data_valid;
    logic       error;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: an entry is a count of whole digits, their value, and optional point/half digit
    int m_n;
    int m_val;
    bit m_pt;
    bit m_hf;
    bit m_half;
    int exp_data;
    bit exp_dec;
    bit exp_dv;
    bit exp_err;
    bit exp_busy;

    always #5 clk = ~clk;

`ifdef DECIMAL_BINARY_TIMEOUT_EN
    decimal_binary #(.TIMEOUT_CYCLES(16)) dut (
`else
    decimal_binary dut (
`endif
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .data        (data),
        .decimal     (decimal),
        .data_valid  (data_valid),
        .error       (error),
        .busy        (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_n = 0; m_val = 0; m_pt = 1'b0; m_hf = 1'b0; m_half = 1'b0;
    endtask

    task automatic m_reject();
        exp_err = 1'b1;
        m_clear();
    endtask

    task automatic m_key(input int k);
        if (k >= 12) begin
            m_reject();
        end else if (k <= 9) begin
            if (m_pt) begin
                if (m_hf) m_reject();
                else if (k == 0 || k == 5) begin
                    m_hf = 1'b1;
                    m_half = (k == 5);
                end else m_reject();
            end else if (m_n == 2) begin
                m_reject();
            end else begin
                m_val = m_val * 10 + k;
                m_n++;
            end
        end else if (k == 11) begin
            if (m_pt) m_reject();
            else m_pt = 1'b1;
        end else begin
            if ((m_n == 0 && !m_pt) || (m_pt && !m_hf) || m_val > 99) begin
                m_reject();
            end else begin
                exp_data = m_val;
                exp_dec  = m_half;
                exp_dv   = 1'b1;
                m_clear();
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clear();
            exp_data = 0; exp_dec = 1'b0; exp_dv = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        end else begin
            exp_dv  = 1'b0;
            exp_err = 1'b0;
            if (digit_valid) m_key(int'(digit));
            exp_busy = (m_n > 0) || m_pt;
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("data", int'(data), exp_data);
            check("decimal", int'(decimal), int'(exp_dec));
            check("data_valid", int'(data_valid), int'(exp_dv));
            check("error", int'(error), int'(exp_err));
            check("busy", int'(busy), int'(exp_busy));
        end
    end

    task automatic key(input int k);
        digit_valid = 1'b1;
        digit = 4'(k);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        digit_valid = 1'b0;
        digit = 4'd0;
        idle(2);
        check("rst_data", int'(data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dv", int'(data_valid), 0);
        check("rst_err", int'(error), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        key(2); key(5); key(11); key(5); key(10);
        check("t1_data", int'(data), 25);
        check("t1_dec", int'(decimal), 1);
        check("t1_dv", int'(data_valid), 1);
        check("t1_busy", int'(busy), 0);
        idle(1);
        check("t1_dv_once", int'(data_valid), 0);

        key(1); key(2); key(3);
        check("ovf_err", int'(error), 1);
        check("ovf_busy", int'(busy), 0);
        check("ovf_data", int'(data), 25);
        key(4); key(10);
        check("t4_data", int'(data), 4);
        idle(1);

        key(7); key(10);
        check("t7_data", int'(data), 7);
        check("t7_dec", int'(decimal), 0);
        key(11); key(0); key(10);
        check("pt0_data", int'(data), 0);
        check("pt0_dv", int'(data_valid), 1);
        idle(1);

        key(11); key(6);
        check("pt6_err", int'(error), 1);
        key(10);
        check("empty_commit_err", int'(error), 1);
        check("empty_commit_dv", int'(data_valid), 0);
        key(9); key(9); key(10);
        check("t99_data", int'(data), 99);
        key(2); key(13);
        check("illegal_err", int'(error), 1);
        check("illegal_data", int'(data), 99);
        key(12); key(11); key(11); key(11); key(5); key(5); key(10);
        key(5); key(11); key(0); key(10);
        check("t5p0_data", int'(data), 5);
        key(11); key(10); key(3); key(11); key(5); key(10);
        check("t3p5_dec", int'(decimal), 1);
        idle(2);

        key(3); key(4);
        #2;
        reset = 1'b1;
        #1;
        check("async_data", int'(data), 0);
        check("async_busy", int'(busy), 0);
        check("async_dec", int'(decimal), 0);
        idle(1);
        reset = 1'b0;
        key(10);
        check("post_rst_err", int'(error), 1);
        check("post_rst_dv", int'(data_valid), 0);
        idle(2);

`ifdef DECIMAL_BINARY_TIMEOUT_EN
        chk_en = 1'b0;
        key(8);
        idle(15);
        check("to_early", int'(error), 0);
        idle(1);
        check("to_err", int'(error), 1);
        check("to_busy", int'(busy), 0);
        key(10);
        check("to_commit_err", int'(error), 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
